// File: rtl/cu_write_stream_engine_if.sv
// Bundles the element input stream, the write command bus and the write
// response channel of the CU write stream engine.
//
//   in_valid/in_data/in_ready     element stream from the CU datapath
//   cmd_valid/cmd_ready           write command handshake to the arbiter
//   cmd_address/size/data/cu_id   write command payload
//   rsp_valid/rsp_fail            response for the single outstanding command
//
// master: the engine side.  slave: the datapath / arbiter side.
interface cu_write_stream_engine_if #(
    parameter int ELEM_BYTES = 4,
    parameter int LINE_BYTES = 128
);
    logic                    in_valid;
    logic [ELEM_BYTES*8-1:0] in_data;
    logic                    in_ready;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [63:0]             cmd_address;
    logic [11:0]             cmd_size;
    logic [LINE_BYTES*8-1:0] cmd_data;
    logic [7:0]              cmd_cu_id;

    logic                    rsp_valid;
    logic                    rsp_fail;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output cmd_valid,
        input  cmd_ready,
        output cmd_address, cmd_size, cmd_data, cmd_cu_id,
        input  rsp_valid, rsp_fail
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_address, cmd_size, cmd_data, cmd_cu_id,
        output rsp_valid, rsp_fail
    );
endinterface

// File: rtl/cu_write_stream_engine.sv
// CU write stream engine: takes an in-order stream of big-endian array
// elements, byte-swaps each one to host order, packs them into a cacheline
// buffer and issues one write command per line (power-of-two size), waiting
// for the response of each command before filling the next line. Failed
// writes are reissued unchanged. done pulses once every line is acknowledged.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   start                 one-cycle pulse, latches base_address/num_elements
//   base_address          128-byte aligned byte address of the output array
//   num_elements          number of elements to write
//   bus                   element stream, command bus and response channel
//   busy                  high from SET through DONE
//   done                  one-cycle completion pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// SET     | clear counters and line buffer, skip to DONE if no elements
// FILL    | accepting elements into the line buffer
// REQ     | presenting the write command for the current line
// PENDING | command accepted, waiting for its response
// DONE    | one-cycle done pulse
module cu_write_stream_engine #(
    parameter int ELEM_BYTES     = 4,
    parameter int LINE_BYTES     = 128,
    parameter int ELEMS_PER_LINE = LINE_BYTES / ELEM_BYTES,
    parameter int CU_ID          = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [63:0]                      base_address,
    input  logic [31:0]                      num_elements,
    cu_write_stream_engine_if.master         bus,
    output logic                             busy,
    output logic                             done
);

    localparam int          ELEM_W       = ELEM_BYTES * 8;
    localparam int          LINE_W       = LINE_BYTES * 8;
    localparam logic [31:0] EPL_W        = 32'(ELEMS_PER_LINE);
    localparam logic [31:0] ELEM_BYTES_W = 32'(ELEM_BYTES);
    localparam logic [31:0] LINE_BYTES_W = 32'(LINE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_FILL,
        ST_REQ,
        ST_PENDING,
        ST_DONE
    } state_t;

    state_t              state_q,       state_d;
    logic [63:0]         base_q,        base_d;
    logic [31:0]         num_q,         num_d;
    logic [31:0]         elem_count_q,  elem_count_d;
    logic [31:0]         line_count_q,  line_count_d;
    logic [31:0]         line_fill_q,   line_fill_d;
    logic [LINE_W-1:0]   line_buf_q,    line_buf_d;
    logic [63:0]         cmd_address_q, cmd_address_d;
    logic [11:0]         cmd_size_q,    cmd_size_d;

    logic [ELEM_W-1:0]   elem_swapped;
    logic                in_ready;
    logic                cmd_valid;

    // Smallest power of two >= nbytes, never larger than one line.
    function automatic logic [11:0] pow2_size(input logic [31:0] nbytes);
        logic [31:0] s;
        s = 32'd1;
        for (int i = 0; i < 12; i++) begin
            if (s < nbytes && s < LINE_BYTES_W) begin
                s = s << 1;
            end
        end
        return s[11:0];
    endfunction

    // Big-endian element to host order: byte k moves to byte ELEM_BYTES-1-k.
    always_comb begin
        elem_swapped = '0;
        for (int k = 0; k < ELEM_BYTES; k++) begin
            elem_swapped[(ELEM_BYTES-1-k)*8 +: 8] = bus.in_data[k*8 +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            num_q         <= '0;
            elem_count_q  <= '0;
            line_count_q  <= '0;
            line_fill_q   <= '0;
            line_buf_q    <= '0;
            cmd_address_q <= '0;
            cmd_size_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            elem_count_q  <= elem_count_d;
            line_count_q  <= line_count_d;
            line_fill_q   <= line_fill_d;
            line_buf_q    <= line_buf_d;
            cmd_address_q <= cmd_address_d;
            cmd_size_q    <= cmd_size_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        num_d         = num_q;
        elem_count_d  = elem_count_q;
        line_count_d  = line_count_q;
        line_fill_d   = line_fill_q;
        line_buf_d    = line_buf_q;
        cmd_address_d = cmd_address_q;
        cmd_size_d    = cmd_size_q;
        in_ready      = 1'b0;
        cmd_valid     = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base_address;
                    num_d   = num_elements;
                    state_d = ST_SET;
                end
            end

            ST_SET: begin
                elem_count_d = '0;
                line_count_d = '0;
                line_fill_d  = '0;
                line_buf_d   = '0;
                state_d      = (num_q == 32'd0) ? ST_DONE : ST_FILL;
            end

            ST_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    for (int s = 0; s < ELEMS_PER_LINE; s++) begin
                        if (line_fill_q == 32'(s)) begin
                            line_buf_d[s*ELEM_W +: ELEM_W] = elem_swapped;
                        end
                    end
                    line_fill_d  = line_fill_q + 32'd1;
                    elem_count_d = elem_count_q + 32'd1;
                    // Command fields are registered here so REQ starts with
                    // them already valid, one cycle after the closing element.
                    if (line_fill_d == EPL_W || elem_count_d == num_q) begin
                        cmd_address_d = base_q + 64'(line_count_q) * 64'(LINE_BYTES);
                        cmd_size_d    = pow2_size(line_fill_d * ELEM_BYTES_W);
                        state_d       = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                cmd_valid = 1'b1;
                if (bus.cmd_ready) begin
                    state_d = ST_PENDING;
                end
            end

            ST_PENDING: begin
                if (bus.rsp_valid) begin
                    if (bus.rsp_fail) begin
                        // Address, size and buffer are untouched, so the
                        // reissued command is identical.
                        state_d = ST_REQ;
                    end else begin
                        line_count_d = line_count_q + 32'd1;
                        line_fill_d  = '0;
                        line_buf_d   = '0;
                        state_d      = (elem_count_q == num_q) ? ST_DONE : ST_FILL;
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy            = (state_q != ST_IDLE);
    assign bus.in_ready    = in_ready;
    assign bus.cmd_valid   = cmd_valid;
    assign bus.cmd_address = cmd_address_q;
    assign bus.cmd_size    = cmd_size_q;
    assign bus.cmd_data    = line_buf_q;
    assign bus.cmd_cu_id   = 8'(CU_ID);

endmodule

// File: tb/tb_cu_write_stream_engine.sv
// Scoreboard bench for cu_write_stream_engine: expected write commands are
// built from the generated element stream and queued before each run, then
// popped and compared as the engine hands them to the arbiter.
module tb_cu_write_stream_engine;

    localparam int EB  = 4;
    localparam int LB  = 128;
    localparam int EPL = LB / EB;

    typedef struct {
        logic [63:0]     addr;
        logic [11:0]     size;
        logic [LB*8-1:0] data;
    } cmd_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   base_address;
    logic [31:0]   num_elements;
    logic          busy;
    logic          done;

    cmd_t          exp_q[$];
    logic [31:0]   elems[$];
    int            vectors     = 0;
    int            miscompares = 0;

    always #5 clock = ~clock;

    cu_write_stream_engine_if #(.ELEM_BYTES(EB), .LINE_BYTES(LB)) bus ();

    cu_write_stream_engine #(
        .ELEM_BYTES    (EB),
        .LINE_BYTES    (LB),
        .ELEMS_PER_LINE(EPL),
        .CU_ID         (0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_address(base_address),
        .num_elements(num_elements),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [11:0] size_for(input int nbytes);
        if (nbytes <= 4)  return 12'd4;
        if (nbytes <= 8)  return 12'd8;
        if (nbytes <= 16) return 12'd16;
        if (nbytes <= 32) return 12'd32;
        if (nbytes <= 64) return 12'd64;
        return 12'd128;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        chk({tag, "_cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
        chk({tag, "_cmd_addr"},  bus.cmd_address, 64'd0);
        chk({tag, "_cmd_size"},  64'(bus.cmd_size), 64'd0);
        chk({tag, "_cmd_data"},  64'(|bus.cmd_data), 64'd0);
        chk({tag, "_busy"},      64'(busy), 64'd0);
        chk({tag, "_done"},      64'(done), 64'd0);
        chk({tag, "_cu_id"},     64'(bus.cmd_cu_id), 64'd0);
    endtask

    task automatic run_test(input logic [63:0] base, input int n, input int bp,
                            input bit fail_first, input bit poke_start, input string name);
        cmd_t        c;
        int          n_cmds;
        int          idx = 0, held = 0, cmds_seen = 0, resp_count = 0, done_count = 0;
        int          done_t = -1, last_rsp_t = -1, line_acc_t = -1, rsp_cd = -1;
        bit          rsp_bad = 1'b0, retry_pending, reissue = 1'b0, prev_cv = 1'b0, accept;
        logic [63:0] h_addr;
        logic [11:0] h_size;
        logic [LB*8-1:0] h_data;

        retry_pending = fail_first;
        elems.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            elems.push_back(i == 0 ? 32'h1122_3344 : $urandom);
        end
        for (int l = 0; l * EPL < n; l++) begin
            int cnt = (n - l * EPL > EPL) ? EPL : n - l * EPL;
            c.addr = base + 64'(l) * 64'(LB);
            c.size = size_for(cnt * EB);
            c.data = '0;
            for (int j = 0; j < cnt; j++) begin
                c.data[j*32 +: 32] = swap32(elems[l*EPL + j]);
            end
            exp_q.push_back(c);
        end
        n_cmds = exp_q.size();

        @(posedge clock); #1;
        base_address = base;
        num_elements = 32'(n);
        start        = 1'b1;
        @(posedge clock); #1;
        start        = 1'b0;
        base_address = ~base;
        num_elements = 32'hFFFF_FFFF;
        chk({name, "_busy"}, 64'(busy), 64'd1);

        for (int t = 1; t < 400 + n * 4 + bp; t++) begin
            start        = poke_start && (t == 5);
            bus.in_valid = (idx < n);
            bus.in_data  = (idx < n) ? elems[idx] : 32'd0;
            accept       = bus.in_valid && bus.in_ready;
            if (accept && (((idx + 1) % EPL) == 0 || idx + 1 == n)) line_acc_t = t;

            bus.rsp_valid = 1'b0;
            bus.rsp_fail  = 1'b0;
            if (rsp_cd == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_fail  = rsp_bad;
                reissue       = rsp_bad;
                last_rsp_t    = t;
                resp_count++;
                rsp_cd        = -1;
            end else if (rsp_cd > 0) begin
                rsp_cd--;
            end

            bus.cmd_ready = 1'b0;
            if (bus.cmd_valid) begin
                if (!prev_cv) begin
                    if (!reissue) chk({name, "_req_latency"}, 64'(t - line_acc_t), 64'd1);
                    reissue = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    chk({name, "_extra_cmd"}, 64'(cmds_seen + 1), 64'(n_cmds));
                end else if (cmds_seen == 0 && held < bp) begin
                    if (held == 0) begin
                        h_addr = bus.cmd_address;
                        h_size = bus.cmd_size;
                        h_data = bus.cmd_data;
                    end else begin
                        chk({name, "_bp_addr"}, bus.cmd_address, h_addr);
                        chk({name, "_bp_size"}, 64'(bus.cmd_size), 64'(h_size));
                        chk({name, "_bp_data"}, 64'(bus.cmd_data == h_data), 64'd1);
                    end
                    chk({name, "_bp_in_ready"}, 64'(bus.in_ready), 64'd0);
                    held++;
                end else begin
                    bus.cmd_ready = 1'b1;
                    chk({name, "_addr"}, bus.cmd_address, exp_q[0].addr);
                    chk({name, "_size"}, 64'(bus.cmd_size), 64'(exp_q[0].size));
                    for (int w = 0; w < LB / 8; w++) begin
                        chk({name, "_data_w", $sformatf("%0d", w)},
                            bus.cmd_data[w*64 +: 64], exp_q[0].data[w*64 +: 64]);
                    end
                    if (cmds_seen == 0) chk({name, "_elem0"}, 64'(bus.cmd_data[31:0]), 64'h4433_2211);
                    if (retry_pending) begin
                        rsp_bad       = 1'b1;
                        retry_pending = 1'b0;
                    end else begin
                        rsp_bad = 1'b0;
                        void'(exp_q.pop_front());
                    end
                    cmds_seen++;
                    rsp_cd = 2;
                end
            end
            prev_cv = bus.cmd_valid;

            if (done) begin
                done_count++;
                done_t = t;
            end

            @(posedge clock); #1;
            if (accept) idx++;
            if (done_t >= 0 && t > done_t + 2) break;
        end
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_fail  = 1'b0;

        chk({name, "_done_pulses"}, 64'(done_count), 64'd1);
        chk({name, "_cmds_left"},   64'(exp_q.size()), 64'd0);
        chk({name, "_responses"},   64'(resp_count), 64'(n_cmds + (fail_first ? 1 : 0)));
        chk({name, "_elems_taken"}, 64'(idx), 64'(n));
        if (n == 0) chk({name, "_done_latency"}, 64'(done_t), 64'd2);
        else        chk({name, "_done_after_rsp"}, 64'(done_t - last_rsp_t), 64'd1);
        chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int  acc;
        bit  a;
        bit  saw_done;

        reset         = 1'b1;
        start         = 1'b0;
        base_address  = '0;
        num_elements  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_fail  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        run_test(64'h1000, 32, 0,  1'b0, 1'b0, "full_line");
        run_test(64'h2000, 37, 0,  1'b0, 1'b1, "tail");
        run_test(64'h4000, 1,  0,  1'b0, 1'b0, "n1");
        run_test(64'h4080, 2,  0,  1'b0, 1'b0, "n2");
        run_test(64'h4100, 3,  0,  1'b0, 1'b0, "n3");
        run_test(64'h4180, 0,  0,  1'b0, 1'b0, "n0");
        run_test(64'h5000, 32, 10, 1'b0, 1'b0, "backpressure");
        run_test(64'h6000, 37, 0,  1'b1, 1'b0, "retry");
        run_test(64'hFFFF_FFFF_FFFF_FF80, 40, 0, 1'b0, 1'b0, "addr_wrap");

        @(posedge clock); #1;
        base_address = 64'h3000;
        num_elements = 32'd32;
        start        = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        acc   = 0;
        for (int t = 0; t < 100 && acc < 10; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            a = bus.in_ready;
            @(posedge clock); #1;
            if (a) acc++;
        end
        bus.in_valid = 1'b0;
        chk("midrst_accepted", 64'(acc), 64'd10);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("midrst");
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            saw_done = saw_done | done;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);

        run_test(64'h3000, 32, 0, 1'b0, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cu_write_stream_engine.md
Name: cu_write_stream_engine

Overview:
- Transmit-side counterpart of the compute unit read stream.
- Accepts an in-order stream of processed array elements from the CU datapath and byte-swaps each one from big-endian to host order.
- Packs elements into cacheline buffers and issues write commands with power-of-two sizes toward the CU command arbiter.
- Tracks write responses and signals completion once every line of the output array is acknowledged.

Parameters:
- ELEM_BYTES, 4, bytes per array element.
- LINE_BYTES, 128, cacheline bytes; maximum command size.
- ELEMS_PER_LINE, LINE_BYTES/ELEM_BYTES (32), elements per line.
- CU_ID, 0, compute unit identifier attached to every command.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches base_address and num_elements.
- base_address  in  64  byte address of output array; 128-byte aligned.
- num_elements  in  32  number of elements to write.
- in_valid  in  1  element available.
- in_data  in  ELEM_BYTES*8  element, big-endian.
- in_ready  out  1  element accepted when in_valid && in_ready.
- cmd_valid  out  1  write command valid.
- cmd_ready  in  1  arbiter accepts command when cmd_valid && cmd_ready.
- cmd_address  out  64  line address.
- cmd_size  out  12  byte count: 1, 2, 4, 8, 16, 32, 64 or 128.
- cmd_data  out  LINE_BYTES*8  line payload.
- cmd_cu_id  out  8  equals CU_ID.
- rsp_valid  in  1  write response for the outstanding command.
- rsp_fail  in  1  qualified by rsp_valid; command must be reissued.
- busy  out  1  high from SET through DONE.
- done  out  1  one-cycle pulse when all lines are acknowledged.

Behaviour:
- Reset values: in_ready=0, cmd_valid=0, cmd_address=0, cmd_size=0, cmd_data=0, busy=0, done=0. Internal counters and the line buffer clear to 0. State goes to IDLE.
- Reset asserted mid-operation aborts immediately: in-flight command is dropped, no done pulse.
- FSM states: IDLE, SET, FILL, REQ, PENDING, DONE.
- IDLE:
  - start moves to SET.
  - start outside IDLE is ignored.
- SET (one cycle):
  - Latch parameters; clear elem_count, line_count, line_fill.
  - num_elements==0 goes to DONE; otherwise goes to FILL.
- FILL:
  - in_ready=1.
  - Each accepted element is byte-reversed (byte k becomes byte ELEM_BYTES-1-k) and written at byte offset line_fill*ELEM_BYTES of the line buffer.
  - line_fill increments; elem_count increments.
  - Moves to REQ in the cycle after the acceptance that makes line_fill==ELEMS_PER_LINE or elem_count==num_elements.
- REQ:
  - in_ready=0, cmd_valid=1.
  - cmd_address = base + line_count*LINE_BYTES.
  - cmd_size = smallest power of two ≥ line_fill*ELEM_BYTES, capped at 128.
  - Unfilled bytes in cmd_data are 0. Host buffers are padded to a 128-byte multiple.
  - cmd_address, cmd_size and cmd_data hold stable while cmd_valid && !cmd_ready.
  - Handshake moves to PENDING; cmd_valid drops the following cycle.
- PENDING:
  - Exactly one command is outstanding per engine.
  - rsp_valid && rsp_fail returns to REQ with identical address, size and data.
  - rsp_valid && !rsp_fail increments line_count and clears line_fill and the buffer. Then:
    - elem_count==num_elements goes to DONE.
    - otherwise returns to FILL.
  - rsp_valid arriving in REQ is a protocol error and is ignored.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Counters are 32 bits.
  - Address add is 64-bit modulo, with no overflow detection.
- Element-to-command latency: first REQ cycle is one cycle after the last element accepted for that line.

Test Plan:
- Exactly one full line: num_elements=32, base=0x1000, in_valid held high → one command at 0x1000, size 128; elements 0..31 byte-swapped (0x11223344 becomes 0x44332211 at bytes 0..3); done 1 cycle after the response.
- Partial tail: num_elements=37 → commands at base (size 128) and base+128 (size 32, 20 valid bytes, bytes 20..31 zero); exactly 2 responses, then one done pulse.
- Small sizes: num_elements=1 → size 4; num_elements=2 → size 8; num_elements=3 → size 16; num_elements=0 → done 2 cycles after start, no command.
- Backpressure: cmd_ready held low for 10 cycles → cmd_valid, address, size and data stable across those cycles; in_ready=0 throughout.
- Retry: first response rsp_fail=1 → same address, size and data reissued; second response ok → stream continues; line_count advances once.
- Reset mid-line after 10 elements accepted → all outputs at reset values the next cycle; a new start with num_elements=32 completes normally with a size-128 command.
